// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_unit
//  Description : Owns the PC and fetches one instruction word from
//                instruction memory per W_PC strobe. The fetch is abandoned
//                after IM_TIMEOUT cycles without a response. The word is
//                latched into IR and its fixed fields are decoded. Taken
//                branches resolved in EX redirect the next fetch.
//                Optional macro FETCH_DECODE_LINK_EN builds the LINK_PC
//                return-address register; without it LINK_PC is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IM_TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP_WORD   = 32'h3F00_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              W_PC,
  input  logic              BR_VALID,
  input  logic              BR_TAKE,
  input  logic [ADDR_W-1:0] BR_TARGET,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic              IM_RD,
  input  logic [DATA_W-1:0] IM_RDATA,
  input  logic              IM_VALID,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [2:0]        TYPE,
  output logic [4:0]        OP,
  output logic [3:0]        RD,
  output logic [3:0]        RA,
  output logic [3:0]        RB,
  output logic [15:0]       IMM,
  output logic              IR_VALID,
  output logic              BUSY,
  output logic              FETCH_ERR,
  output logic [ADDR_W-1:0] LINK_PC
);

  // Counter must be able to hold IM_TIMEOUT itself.
  localparam int CNT_W = $clog2(IM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                redir_pend_q, redir_pend_d;
  logic [ADDR_W-1:0]   redir_tgt_q, redir_tgt_d;
  logic [ADDR_W-1:0]   w_fetch_addr;
`ifdef FETCH_DECODE_LINK_EN
  logic [ADDR_W-1:0]   link_q, link_d;
`endif

  // Fetch address: a branch resolving this very cycle takes precedence over
  // a pending redirect, so a same-cycle W_PC sees the newest branch outcome.
  always_comb begin
    w_fetch_addr = pc_q;
    if (BR_VALID && BR_TAKE) begin
      w_fetch_addr = BR_TARGET;
    end else if (!BR_VALID && redir_pend_q) begin
      w_fetch_addr = redir_tgt_q;
    end
  end

  // Next-state, redirect tracking and IR update logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    im_addr_d    = im_addr_q;
    ir_d         = ir_q;
    ir_valid_d   = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
`ifdef FETCH_DECODE_LINK_EN
    link_d       = link_q;
`endif

    // Branch outcomes are recorded in every state; a fetch started in IDLE
    // below consumes (and clears) them.
    if (BR_VALID) begin
      if (BR_TAKE) begin
        redir_pend_d = 1'b1;
        redir_tgt_d  = BR_TARGET;
      end else begin
        redir_pend_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (W_PC) begin
          im_addr_d    = w_fetch_addr;
          pc_d         = w_fetch_addr + ADDR_W'(1);
          redir_pend_d = 1'b0;
`ifdef FETCH_DECODE_LINK_EN
          link_d       = w_fetch_addr + ADDR_W'(1);
`endif
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (W_PC) begin
          err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (W_PC) begin
          err_d = 1'b1;
        end
        if (IM_VALID) begin
          ir_d       = IM_RDATA;
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(IM_TIMEOUT)) begin
            ir_d       = NOP_WORD;
            err_d      = 1'b1;
            ir_valid_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      im_addr_q    <= '0;
      ir_q         <= NOP_WORD;
      ir_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      im_addr_q    <= im_addr_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

`ifdef FETCH_DECODE_LINK_EN
  // Return-address register, loaded alongside PC when a fetch starts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      link_q <= '0;
    end else begin
      link_q <= link_d;
    end
  end
  assign LINK_PC = link_q;
`else
  assign LINK_PC = '0;
`endif

  assign IM_ADDR   = im_addr_q;
  assign IM_RD     = (state_q == S_REQ);
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign TYPE      = ir_q[31:29];
  assign OP        = ir_q[28:24];
  assign RD        = ir_q[23:20];
  assign RA        = ir_q[19:16];
  assign RB        = ir_q[15:12];
  assign IMM       = ir_q[15:0];
  assign IR_VALID  = ir_valid_q;
  assign BUSY      = (state_q != S_IDLE);
  assign FETCH_ERR = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_unit
//  Description : Directed self-checking bench for fetch_decode_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        W_PC;
  logic        BR_VALID;
  logic        BR_TAKE;
  logic [15:0] BR_TARGET;
  logic [15:0] IM_ADDR;
  logic        IM_RD;
  logic [31:0] IM_RDATA;
  logic        IM_VALID;
  logic [15:0] PC;
  logic [31:0] IR;
  logic [2:0]  TYPE;
  logic [4:0]  OP;
  logic [3:0]  RD;
  logic [3:0]  RA;
  logic [3:0]  RB;
  logic [15:0] IMM;
  logic        IR_VALID;
  logic        BUSY;
  logic        FETCH_ERR;
  logic [15:0] LINK_PC;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_decode_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .W_PC      (W_PC),
    .BR_VALID  (BR_VALID),
    .BR_TAKE   (BR_TAKE),
    .BR_TARGET (BR_TARGET),
    .IM_ADDR   (IM_ADDR),
    .IM_RD     (IM_RD),
    .IM_RDATA  (IM_RDATA),
    .IM_VALID  (IM_VALID),
    .PC        (PC),
    .IR        (IR),
    .TYPE      (TYPE),
    .OP        (OP),
    .RD        (RD),
    .RA        (RA),
    .RB        (RB),
    .IMM       (IMM),
    .IR_VALID  (IR_VALID),
    .BUSY      (BUSY),
    .FETCH_ERR (FETCH_ERR),
    .LINK_PC   (LINK_PC)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Drives one fetch with IM answering k cycles after IM_RD; returns the
  // address seen during the IM_RD cycle and W_PC-to-IR_VALID latency.
  task automatic fetch(input int k, input logic [31:0] data,
                       output logic [15:0] addr_seen, output logic rd_seen,
                       output int lat);
    int n;
    W_PC = 1'b1;
    step();
    W_PC = 1'b0;
    addr_seen = IM_ADDR;
    rd_seen   = IM_RD;
    repeat (k) step();
    IM_RDATA = data;
    IM_VALID = 1'b1;
    step();
    IM_VALID = 1'b0;
    n = 0;
    while (IR_VALID !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    lat = 2 + k + n;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (PC !== 16'h0000) begin n_mis++; $display("FAIL reset_pc: got %h want %h", PC, 16'h0000); end
    n_cmp++; if (IR !== 32'h3F00_0000) begin n_mis++; $display("FAIL reset_ir: got %h want %h", IR, 32'h3F00_0000); end
    n_cmp++; if (TYPE !== 3'b001 || OP !== 5'b11111) begin n_mis++; $display("FAIL reset_type_op: got %b/%b want 001/11111", TYPE, OP); end
    n_cmp++; if (IM_RD !== 1'b0 || IM_ADDR !== 16'h0000) begin n_mis++; $display("FAIL reset_im: got rd=%b addr=%h want 0/0000", IM_RD, IM_ADDR); end
    n_cmp++; if (IR_VALID !== 1'b0 || BUSY !== 1'b0 || FETCH_ERR !== 1'b0) begin n_mis++; $display("FAIL reset_flags: got irv=%b busy=%b err=%b want 0/0/0", IR_VALID, BUSY, FETCH_ERR); end
    n_cmp++; if (LINK_PC !== 16'h0000) begin n_mis++; $display("FAIL reset_link: got %h want 0000", LINK_PC); end
  endtask

  task automatic test_basic_fetch();
    logic [15:0] a;
    logic        rd;
    int          lat;
    do_reset();
    fetch(2, 32'h2A31_2000, a, rd, lat);
    n_cmp++; if (a !== 16'h0000 || rd !== 1'b1) begin n_mis++; $display("FAIL basic_req: got addr=%h rd=%b want 0000/1", a, rd); end
    n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL basic_latency: got %0d want %0d", lat, 4); end
    n_cmp++; if (IR !== 32'h2A31_2000) begin n_mis++; $display("FAIL basic_ir: got %h want 2a312000", IR); end
    n_cmp++; if (TYPE !== 3'b001 || OP !== 5'b01010) begin n_mis++; $display("FAIL basic_type_op: got %b/%b want 001/01010", TYPE, OP); end
    n_cmp++; if (RD !== 4'd3 || RA !== 4'd1 || RB !== 4'd2) begin n_mis++; $display("FAIL basic_regs: got %0d/%0d/%0d want 3/1/2", RD, RA, RB); end
    n_cmp++; if (IMM !== 16'h2000) begin n_mis++; $display("FAIL basic_imm: got %h want 2000", IMM); end
    n_cmp++; if (PC !== 16'h0001) begin n_mis++; $display("FAIL basic_pc: got %h want 0001", PC); end
    step();
    n_cmp++; if (IR_VALID !== 1'b0 || IR !== 32'h2A31_2000 || BUSY !== 1'b0) begin n_mis++; $display("FAIL basic_hold: got irv=%b ir=%h busy=%b want 0/2a312000/0", IR_VALID, IR, BUSY); end
  endtask

  task automatic test_sequential();
    logic [15:0] a;
    logic        rd;
    int          lat;
    logic [15:0] exp_link;
`ifdef FETCH_DECODE_LINK_EN
    exp_link = 16'h0003;
`else
    exp_link = 16'h0000;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(1, 32'h1000_0000 + i, a, rd, lat);
      n_cmp++; if (a !== 16'(i)) begin n_mis++; $display("FAIL seq_addr%0d: got %h want %h", i, a, 16'(i)); end
      n_cmp++; if (lat !== 3 || IR !== 32'h1000_0000 + i) begin n_mis++; $display("FAIL seq_data%0d: got lat=%0d ir=%h want 3/%h", i, lat, IR, 32'h1000_0000 + i); end
      step();
    end
    n_cmp++; if (PC !== 16'h0003) begin n_mis++; $display("FAIL seq_pc: got %h want 0003", PC); end
    n_cmp++; if (LINK_PC !== exp_link) begin n_mis++; $display("FAIL seq_link: got %h want %h", LINK_PC, exp_link); end
  endtask

  task automatic test_redirect_busy();
    logic [15:0] a;
    logic        rd;
    int          lat;
    do_reset();
    W_PC = 1'b1;
    step();
    W_PC = 1'b0;
    BR_VALID = 1'b1; BR_TAKE = 1'b1; BR_TARGET = 16'h0040;
    step();
    BR_VALID = 1'b0; BR_TAKE = 1'b0; BR_TARGET = 16'h0000;
    IM_RDATA = 32'h5555_AAAA;
    IM_VALID = 1'b1;
    step();
    IM_VALID = 1'b0;
    n_cmp++; if (IR_VALID !== 1'b1 || PC !== 16'h0001 || IR !== 32'h5555_AAAA) begin n_mis++; $display("FAIL redir_busy_fetch: got irv=%b pc=%h ir=%h want 1/0001/5555aaaa", IR_VALID, PC, IR); end
    step();
    fetch(1, 32'h0000_0001, a, rd, lat);
    n_cmp++; if (a !== 16'h0040 || PC !== 16'h0041) begin n_mis++; $display("FAIL redir_target: got addr=%h pc=%h want 0040/0041", a, PC); end
    step();
    fetch(1, 32'h0000_0002, a, rd, lat);
    n_cmp++; if (a !== 16'h0041 || PC !== 16'h0042) begin n_mis++; $display("FAIL redir_next: got addr=%h pc=%h want 0041/0042", a, PC); end
    step();
  endtask

  task automatic test_bypass_wrap();
    logic [15:0] a;
    logic        rd;
    int          lat;
    BR_VALID = 1'b1; BR_TAKE = 1'b1; BR_TARGET = 16'hFFFF; W_PC = 1'b1;
    step();
    BR_VALID = 1'b0; BR_TAKE = 1'b0; BR_TARGET = 16'h0000; W_PC = 1'b0;
    n_cmp++; if (IM_ADDR !== 16'hFFFF || IM_RD !== 1'b1 || PC !== 16'h0000) begin n_mis++; $display("FAIL bypass_wrap: got addr=%h rd=%b pc=%h want ffff/1/0000", IM_ADDR, IM_RD, PC); end
    step();
    IM_VALID = 1'b1;
    step();
    IM_VALID = 1'b0;
    step();
    // Taken branch then not-taken branch: the pending redirect is cancelled.
    BR_VALID = 1'b1; BR_TAKE = 1'b1; BR_TARGET = 16'h0080;
    step();
    BR_TAKE = 1'b0; BR_TARGET = 16'h0000;
    step();
    BR_VALID = 1'b0;
    fetch(1, 32'h0000_0003, a, rd, lat);
    n_cmp++; if (a !== 16'h0000 || PC !== 16'h0001) begin n_mis++; $display("FAIL notaken_clear: got addr=%h pc=%h want 0000/0001", a, PC); end
    step();
  endtask

  task automatic test_busy_strobe();
    do_reset();
    W_PC = 1'b1;
    step();
    step();
    W_PC = 1'b0;
    n_cmp++; if (FETCH_ERR !== 1'b1 || BUSY !== 1'b1) begin n_mis++; $display("FAIL busy_strobe_err: got err=%b busy=%b want 1/1", FETCH_ERR, BUSY); end
    IM_RDATA = 32'hC0DE_0001;
    IM_VALID = 1'b1;
    step();
    IM_VALID = 1'b0;
    n_cmp++; if (IR_VALID !== 1'b1 || IR !== 32'hC0DE_0001 || PC !== 16'h0001) begin n_mis++; $display("FAIL busy_strobe_fetch: got irv=%b ir=%h pc=%h want 1/c0de0001/0001", IR_VALID, IR, PC); end
    step();
    n_cmp++; if (BUSY !== 1'b0 || IM_RD !== 1'b0) begin n_mis++; $display("FAIL busy_strobe_dropped: got busy=%b rd=%b want 0/0", BUSY, IM_RD); end
  endtask

  task automatic test_timeout();
    logic [15:0] a;
    logic        rd;
    int          lat;
    do_reset();
    fetch(1, 32'h1234_5678, a, rd, lat);
    step();
    W_PC = 1'b1;
    step();
    W_PC = 1'b0;
    repeat (15) step();
    n_cmp++; if (BUSY !== 1'b1 || IR_VALID !== 1'b0 || FETCH_ERR !== 1'b0) begin n_mis++; $display("FAIL timeout_early: got busy=%b irv=%b err=%b want 1/0/0", BUSY, IR_VALID, FETCH_ERR); end
    step();
    n_cmp++; if (IR_VALID !== 1'b1 || BUSY !== 1'b0) begin n_mis++; $display("FAIL timeout_pulse: got irv=%b busy=%b want 1/0", IR_VALID, BUSY); end
    n_cmp++; if (IR !== 32'h3F00_0000 || TYPE !== 3'b001 || OP !== 5'b11111) begin n_mis++; $display("FAIL timeout_nop: got ir=%h type=%b op=%b want 3f000000/001/11111", IR, TYPE, OP); end
    n_cmp++; if (FETCH_ERR !== 1'b1) begin n_mis++; $display("FAIL timeout_err: got %b want 1", FETCH_ERR); end
    repeat (3) step();
    n_cmp++; if (FETCH_ERR !== 1'b1 || IR_VALID !== 1'b0) begin n_mis++; $display("FAIL timeout_sticky: got err=%b irv=%b want 1/0", FETCH_ERR, IR_VALID); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] a;
    logic        rd;
    int          lat;
    logic        seen_irv;
    do_reset();
    fetch(1, 32'h8765_4321, a, rd, lat);
    step();
    W_PC = 1'b1;
    step();
    W_PC = 1'b0;
    step();
    BR_VALID = 1'b1; BR_TAKE = 1'b1; BR_TARGET = 16'h0055;
    step();
    BR_VALID = 1'b0; BR_TAKE = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    n_cmp++; if (PC !== 16'h0000 || BUSY !== 1'b0 || IR !== 32'h3F00_0000) begin n_mis++; $display("FAIL midreset_state: got pc=%h busy=%b ir=%h want 0000/0/3f000000", PC, BUSY, IR); end
    IM_RDATA = 32'hAAAA_AAAA;
    IM_VALID = 1'b1;
    step();
    IM_VALID = 1'b0;
    seen_irv = IR_VALID;
    step();
    seen_irv = seen_irv | IR_VALID;
    n_cmp++; if (seen_irv !== 1'b0 || IR !== 32'h3F00_0000) begin n_mis++; $display("FAIL midreset_late_valid: got irv=%b ir=%h want 0/3f000000", seen_irv, IR); end
    fetch(1, 32'h0000_0004, a, rd, lat);
    n_cmp++; if (a !== 16'h0000 || PC !== 16'h0001) begin n_mis++; $display("FAIL midreset_redir_cleared: got addr=%h pc=%h want 0000/0001", a, PC); end
  endtask

  initial begin
    RESET = 1'b1; W_PC = 1'b0; BR_VALID = 1'b0; BR_TAKE = 1'b0;
    BR_TARGET = 16'h0000; IM_RDATA = 32'h0; IM_VALID = 1'b0;
    test_reset();
    test_basic_fetch();
    test_sequential();
    test_redirect_busy();
    test_bypass_wrap();
    test_busy_strobe();
    test_timeout();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
